alu_key_loader: RTL and testbench

- Upstream key-delivery stage for the locked ALU datapath.
- Receives the locking key as a serial bit stream with valid/ready handshake and accumulates it LSB-first.
- Checks a trailing even-parity bit, then presents the whole key in parallel on `locking_key` with `key_valid`.
- Until a key is successfully loaded, `locking_key` is all-zero, so the downstream ALU runs in its obfuscated (wrong-key) mode.

---
 rtl/alu_key_loader.sv | 132 +++++++++++++
 tb/tb_alu_key_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_key_loader.sv
// Serial key loader for the locked ALU datapath.
// Accepts KEY_W key bits LSB-first followed by one even-parity bit over a
// valid/ready handshake, checks parity, then presents the key in parallel.
// locking_key stays all-zero until a frame passes, so the ALU runs in its
// wrong-key mode until then.
// Optional feature: define ALU_KEY_LOADER_OTP_EN to make the first good key
// one-time-programmable (start ignored after a successful load until reset).
// KEY_W must be at least 2.
module alu_key_loader #(
  parameter int unsigned KEY_W = 255,
  parameter int unsigned CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             key_sdi,
  input  logic             key_sdi_valid,
  output logic             key_sdi_ready,
  output logic [KEY_W-1:0] locking_key,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [CNT_W-1:0] KeyCnt = CNT_W'(KEY_W);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StCheck
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KEY_W-1:0] shift_q, shift_d;
  logic             par_q, par_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q, err_d;
  logic             start_ok;

`ifdef ALU_KEY_LOADER_OTP_EN
  // A good key is permanent until reset; a failed load may be retried.
  assign start_ok = start & ~key_valid_q;
`else
  assign start_ok = start;
`endif

  // Next-state logic: load sequencing, bit capture and parity verdict.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d     = StShift;
          cnt_d       = '0;
          shift_d     = '0;
          par_d       = 1'b0;
          key_d       = '0;
          key_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      StShift: begin
        if (abort) begin
          state_d = StIdle;
        end else if (key_sdi_valid) begin
          par_d = par_q ^ key_sdi;
          if (cnt_q < KeyCnt) begin
            // Shift in at the top: after KEY_W bits the first bit sits at index 0.
            shift_d = {key_sdi, shift_q[KEY_W-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            // Counter saturated: this was the parity bit.
            state_d = StCheck;
          end
        end
      end
      StCheck: begin
        state_d = StIdle;
        if (!abort) begin
          if (!par_q) begin
            key_d       = shift_q;
            key_valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
    end
  end

  // Outputs: ready and busy decode directly from state.
  always_comb begin
    key_sdi_ready = (state_q == StShift);
    busy          = (state_q != StIdle);
    locking_key   = key_q;
    key_valid     = key_valid_q;
    err           = err_q;
  end

endmodule

// File: tb/tb_alu_key_loader.sv
// Self-checking bench for alu_key_loader: table of frames, hand-written
// reset/abort sequences and random frames checked against a parity model.
module tb_alu_key_loader;

  localparam int KW = 255;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          key_sdi;
  logic          key_sdi_valid;
  logic          key_sdi_ready;
  logic [KW-1:0] locking_key;
  logic          key_valid;
  logic          busy;
  logic          err;

  alu_key_loader #(
    .KEY_W(KW),
    .CNT_W(9)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .key_sdi      (key_sdi),
    .key_sdi_valid(key_sdi_valid),
    .key_sdi_ready(key_sdi_ready),
    .locking_key  (locking_key),
    .key_valid    (key_valid),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Expected visible outputs between loads.
  logic [KW-1:0] m_key;
  logic          m_kv;
  logic          m_err;
`ifdef ALU_KEY_LOADER_OTP_EN
  bit            otp_locked = 1'b0;
`endif

  typedef struct {
    logic [KW-1:0] key;
    logic          par;
    int            pct;
    logic          exp_kv;
    logic          exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Even parity over key plus parity bit.
  function automatic logic frame_ok(input logic [KW-1:0] k, input logic p);
    return ((($countones(k) + int'(p)) % 2) == 0);
  endfunction

  // Drive frame bits [from, nbits) with random valid gaps; returns next index.
  task automatic send_bits(input logic [KW:0] frame, input int from, input int nbits,
                           input int pct, output int sent);
    int   cyc;
    logic xfer;
    cyc  = 0;
    sent = from;
    while (sent < nbits && cyc < 5000) begin
      key_sdi_valid = (int'($urandom_range(1, 100)) <= pct);
      key_sdi       = key_sdi_valid ? frame[sent] : 1'($urandom_range(0, 1));
      xfer          = key_sdi_valid && key_sdi_ready;
      @(negedge clk);
      if (xfer) sent++;
      cyc++;
    end
    key_sdi_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input logic [KW-1:0] key, input logic par, input int pct,
                          input logic exp_kv, input logic exp_err);
    int            sent;
    logic [KW:0]   frame;
    logic [KW-1:0] exp_key;
    frame = {par, key};
    // Previous result holds; bits offered in IDLE are refused.
    chk("hold_key", locking_key, m_key);
    chk("hold_kv", key_valid, m_kv);
    chk("hold_err", err, m_err);
    key_sdi_valid = 1'b1;
    key_sdi       = 1'b1;
    @(negedge clk);
    chk("idle_ready", key_sdi_ready, 1'b0);
    key_sdi_valid = 1'b0;
    pulse_start();
`ifdef ALU_KEY_LOADER_OTP_EN
    if (otp_locked) begin
      logic rdy_seen;
      rdy_seen = 1'b0;
      chk("otp_busy", busy, 1'b0);
      for (int i = 0; i < 20; i++) begin
        key_sdi_valid = 1'b1;
        key_sdi       = 1'($urandom_range(0, 1));
        if (key_sdi_ready) rdy_seen = 1'b1;
        @(negedge clk);
      end
      key_sdi_valid = 1'b0;
      chk("otp_ready", rdy_seen, 1'b0);
      chk("otp_key", locking_key, m_key);
      chk("otp_kv", key_valid, 1'b1);
      return;
    end
`endif
    chk("start_ready", key_sdi_ready, 1'b1);
    chk("start_busy", busy, 1'b1);
    chk("start_kv", key_valid, 1'b0);
    chk("start_key", locking_key, '0);
    chk("start_err", err, 1'b0);
    send_bits(frame, 0, KW + 1, pct, sent);
    chk("frame_sent", KW'(sent), KW'(KW + 1));
    // One cycle in CHECK before the verdict appears.
    chk("check_ready", key_sdi_ready, 1'b0);
    chk("check_busy", busy, 1'b1);
    chk("check_kv", key_valid, 1'b0);
    @(negedge clk);
    exp_key = exp_kv ? key : '0;
    chk("done_kv", key_valid, exp_kv);
    chk("done_err", err, exp_err);
    chk("done_key", locking_key, exp_key);
    chk("done_busy", busy, 1'b0);
    m_key = exp_key;
    m_kv  = exp_kv;
    m_err = exp_err;
`ifdef ALU_KEY_LOADER_OTP_EN
    if (exp_kv) otp_locked = 1'b1;
`endif
  endtask

  task automatic model_reset();
    m_key = '0;
    m_kv  = 1'b0;
    m_err = 1'b0;
`ifdef ALU_KEY_LOADER_OTP_EN
    otp_locked = 1'b0;
`endif
  endtask

  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, "_key"}, locking_key, '0);
    chk({tag, "_kv"}, key_valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_ready"}, key_sdi_ready, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk({tag, "_rel_ready"}, key_sdi_ready, 1'b0);
    chk({tag, "_rel_busy"}, busy, 1'b0);
    model_reset();
  endtask

  initial begin
    int            sent;
    logic [255:0]  rnd;
    logic [KW-1:0] rkey;
    logic          rpar;
    logic [KW:0]   frame;

    vecs[0] = '{key: KW'(9'h19C), par: 1'b1, pct: 100, exp_kv: 1'b1, exp_err: 1'b0};
    vecs[1] = '{key: KW'(9'h19C), par: 1'b0, pct: 100, exp_kv: 1'b0, exp_err: 1'b1};
    vecs[2] = '{key: '1,          par: 1'b1, pct: 50,  exp_kv: 1'b1, exp_err: 1'b0};
    vecs[3] = '{key: '1,          par: 1'b0, pct: 60,  exp_kv: 1'b0, exp_err: 1'b1};
    vecs[4] = '{key: '0,          par: 1'b0, pct: 70,  exp_kv: 1'b1, exp_err: 1'b0};
    vecs[5] = '{key: KW'(3'h5),   par: 1'b1, pct: 80,  exp_kv: 1'b0, exp_err: 1'b1};
    vecs[6] = '{key: KW'(3'h5),   par: 1'b0, pct: 40,  exp_kv: 1'b1, exp_err: 1'b0};

    rst_n         = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    key_sdi       = 1'b0;
    key_sdi_valid = 1'b0;
    model_reset();
    #2;
    async_reset("por");

    // Reset in the middle of a load, 100 bits in.
    frame = {1'b1, {(KW / 2){2'b10}}, 1'b0};
    pulse_start();
    send_bits(frame, 0, 100, 100, sent);
    chk("mid_busy", busy, 1'b1);
    async_reset("midrst");

    for (int i = 0; i < 7; i++) begin
      run_load(vecs[i].key, vecs[i].par, vecs[i].pct, vecs[i].exp_kv, vecs[i].exp_err);
    end

    // Reset clears a loaded key.
    async_reset("loadrst");

`ifndef ALU_KEY_LOADER_OTP_EN
    run_load(KW'(9'h19C), 1'b1, 100, 1'b1, 1'b0);
    // Abort in IDLE does nothing.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_kv", key_valid, 1'b1);
    chk("idle_abort_key", locking_key, KW'(9'h19C));

    // Abort after 10 bits, colliding with a transfer.
    frame = {1'b1, {KW{1'b1}}};
    pulse_start();
    send_bits(frame, 0, 10, 100, sent);
    abort         = 1'b1;
    key_sdi_valid = 1'b1;
    key_sdi       = 1'b1;
    @(negedge clk);
    abort         = 1'b0;
    key_sdi_valid = 1'b0;
    chk("abort_busy", busy, 1'b0);
    chk("abort_ready", key_sdi_ready, 1'b0);
    chk("abort_kv", key_valid, 1'b0);
    chk("abort_key", locking_key, '0);
    chk("abort_err", err, 1'b0);
    m_key = '0;
    m_kv  = 1'b0;
    m_err = 1'b0;
    run_load('1, 1'b1, 100, 1'b1, 1'b0);

    // Abort wins over the CHECK verdict of a good frame.
    pulse_start();
    send_bits(frame, 0, KW + 1, 100, sent);
    chk("ck_abort_state", busy & ~key_sdi_ready, 1'b1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ck_abort_kv", key_valid, 1'b0);
    chk("ck_abort_err", err, 1'b0);
    chk("ck_abort_key", locking_key, '0);
    chk("ck_abort_busy", busy, 1'b0);
    m_key = '0;
    m_kv  = 1'b0;

    // Start and abort together in IDLE: start wins.
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("sa_busy", busy, 1'b1);
    chk("sa_ready", key_sdi_ready, 1'b1);

    // Start mid-shift is ignored: the frame completes from where it was.
    frame = {1'b0, KW'(3'h5)};
    send_bits(frame, 0, 10, 100, sent);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bits(frame, sent, KW + 1, 100, sent);
    chk("ign_start_sent", KW'(sent), KW'(KW + 1));
    @(negedge clk);
    chk("ign_start_kv", key_valid, 1'b1);
    chk("ign_start_key", locking_key, KW'(3'h5));
    m_key = KW'(3'h5);
    m_kv  = 1'b1;
`endif

    // Random frames against the parity model.
    for (int n = 0; n < 6; n++) begin
      for (int w = 0; w < 8; w++) rnd[w*32 +: 32] = $urandom();
      rkey = rnd[KW-1:0];
      rpar = 1'($urandom_range(0, 1));
      run_load(rkey, rpar, int'($urandom_range(30, 100)), frame_ok(rkey, rpar),
               !frame_ok(rkey, rpar));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
